fraction_accumulator4: RTL and testbench

FRACTION_ACCUMULATOR4 -- requirements
Module: fraction_accumulator4

---
 rtl/fraction_accumulator4.sv | 100 ++++++++++
 tb/tb_fraction_accumulator4.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fraction_accumulator4.sv
// Sum-of-products sequencer: launches one multiply per term, accumulates the
// signed 7-bit fraction products into a saturating 9-bit sum.
module fraction_accumulator4 (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       Go,
    input  logic [3:0] Count,
    input  logic       MulDone,
    input  logic [6:0] Product,
    output logic       MulSt,
    output logic [3:0] TermIdx,
    output logic [8:0] Sum,
    output logic       SumValid,
    output logic       Ovf
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] ACC   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]        state;
    logic [3:0]        count_q;
    logic [3:0]        term_q;
    logic              done_q;
    logic              ovf_q;
    logic signed [6:0] product_q;
    logic signed [8:0] sum_q;
    logic signed [9:0] acc_sum;
    logic              done_rise;

    function automatic logic signed [8:0] sat9(input logic signed [9:0] x);
        if (x > 10'sd255)
            return 9'sh0FF;
        else if (x < -10'sd256)
            return 9'sh100;
        return $signed(x[8:0]);
    endfunction

    function automatic logic sat_hit(input logic signed [9:0] x);
        return (x > 10'sd255) || (x < -10'sd256);
    endfunction

    assign done_rise = MulDone && !done_q;
    assign acc_sum   = $signed({sum_q[8], sum_q}) + $signed({{3{product_q[6]}}, product_q});

    // Done history runs in every state so a stale high level never looks like an edge.
    always_ff @(posedge CLK) begin
        if (Rst)
            done_q <= 1'b0;
        else
            done_q <= MulDone;
    end

    always_ff @(posedge CLK) begin
        if (state == WAIT && done_rise)
            product_q <= $signed(Product);
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state   <= IDLE;
            count_q <= 4'd0;
            term_q  <= 4'd0;
            sum_q   <= 9'sd0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (Go) begin
                        sum_q   <= 9'sd0;
                        ovf_q   <= 1'b0;
                        term_q  <= 4'd0;
                        count_q <= Count;
                        state   <= (Count == 4'd0) ? FIN : START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (done_rise)
                        state <= ACC;
                end
                ACC: begin
                    sum_q <= sat9(acc_sum);
                    if (sat_hit(acc_sum))
                        ovf_q <= 1'b1;
                    term_q <= term_q + 4'd1;
                    state  <= (term_q + 4'd1 == count_q) ? FIN : START;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MulSt    = (state == START);
    assign SumValid = (state == FIN);
    assign TermIdx  = term_q;
    assign Sum      = sum_q;
    assign Ovf      = ovf_q;
endmodule

// File: tb/tb_fraction_accumulator4.sv
// Bench for fraction_accumulator4: emulates the multiplier handshake and
// checks results against an integer saturating-sum model.
module tb_fraction_accumulator4;
    logic       CLK = 1'b0;
    logic       Rst = 1'b1;
    logic       Go = 1'b0;
    logic [3:0] Count = 4'd0;
    logic       MulDone = 1'b0;
    logic [6:0] Product = 7'd0;
    logic       MulSt;
    logic [3:0] TermIdx;
    logic [8:0] Sum;
    logic       SumValid;
    logic       Ovf;

    int n_tests = 0;
    int n_fail = 0;
    int sum_m = 0;
    bit ovf_m = 0;
    int mulst_total = 0;
    int mulst_long = 0;
    int mulst_base = 0;
    bit mulst_prev = 0;

    fraction_accumulator4 dut (
        .CLK(CLK), .Rst(Rst), .Go(Go), .Count(Count), .MulDone(MulDone),
        .Product(Product), .MulSt(MulSt), .TermIdx(TermIdx), .Sum(Sum),
        .SumValid(SumValid), .Ovf(Ovf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MulSt) begin
            mulst_total++;
            if (mulst_prev)
                mulst_long++;
        end
        mulst_prev = MulSt;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic model_add(input logic [6:0] p);
        int pv;
        int s;
        pv = $signed(p);
        s = sum_m + pv;
        if (s > 255) begin
            s = 255;
            ovf_m = 1;
        end else if (s < -256) begin
            s = -256;
            ovf_m = 1;
        end
        sum_m = s;
    endtask

    task automatic start_seq(input int cnt);
        mulst_base = mulst_total;
        sum_m = 0;
        ovf_m = 0;
        Count = 4'(cnt);
        Go = 1'b1;
        @(negedge CLK);
        Go = 1'b0;
        Count = 4'($urandom);
    endtask

    task automatic wait_mulst(output bit ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (MulSt === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL mulst_timeout got no MulSt want MulSt=1 within 40 cycles");
        end
    endtask

    task automatic do_term(input int i, input logic [6:0] p, input int dly,
                           input bit hold_in, input bit hold_out);
        bit ok;
        logic [8:0] exp_s;
        wait_mulst(ok);
        if (!ok) return;
        n_tests++;
        if (TermIdx !== 4'(i)) begin
            n_fail++;
            $display("FAIL term_idx got %0d want %0d", TermIdx, i);
        end
        if (hold_in) begin
            repeat (3) @(negedge CLK);
            exp_s = 9'(sum_m);
            n_tests++;
            if (TermIdx !== 4'(i) || (mulst_total - mulst_base) != i + 1 || Sum !== exp_s) begin
                n_fail++;
                $display("FAIL held_done got idx=%0d pulses=%0d sum=%h want idx=%0d pulses=%0d sum=%h",
                         TermIdx, mulst_total - mulst_base, Sum, i, i + 1, exp_s);
            end
            MulDone = 1'b0;
        end
        for (int d = 0; d < dly; d++) begin
            @(negedge CLK);
            Go = 1'($urandom);
        end
        Go = 1'b0;
        Product = p;
        MulDone = 1'b1;
        model_add(p);
        @(negedge CLK);
        n_tests++;
        if (SumValid !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_valid got %b want 0", SumValid);
        end
        if (!hold_out) begin
            MulDone = 1'b0;
            Product = 7'($urandom);
        end
    endtask

    task automatic finish_seq(input int cnt);
        logic [8:0] exp_s;
        logic [8:0] held_s;
        exp_s = 9'(sum_m);
        @(negedge CLK);
        MulDone = 1'b0;
        n_tests++;
        if (SumValid !== 1'b1) begin
            n_fail++;
            $display("FAIL sum_valid got %b want 1", SumValid);
        end
        n_tests++;
        if (Sum !== exp_s) begin
            n_fail++;
            $display("FAIL sum got %h want %h", Sum, exp_s);
        end
        n_tests++;
        if (Ovf !== ovf_m) begin
            n_fail++;
            $display("FAIL ovf got %b want %b", Ovf, ovf_m);
        end
        n_tests++;
        if (TermIdx !== 4'(cnt) || (mulst_total - mulst_base) != cnt || mulst_long != 0) begin
            n_fail++;
            $display("FAIL term_count got idx=%0d pulses=%0d long=%0d want idx=%0d pulses=%0d long=0",
                     TermIdx, mulst_total - mulst_base, mulst_long, cnt, cnt);
        end
        held_s = Sum;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (SumValid !== 1'b1 || Sum !== held_s || Ovf !== ovf_m) begin
            n_fail++;
            $display("FAIL fin_hold got valid=%b sum=%h ovf=%b want valid=1 sum=%h ovf=%b",
                     SumValid, Sum, Ovf, held_s, ovf_m);
        end
    endtask

    task automatic run_seq(input int cnt, input int fixed_p, input bit rand_hold);
        bit prev_hold;
        bit h;
        logic [6:0] p;
        prev_hold = 0;
        start_seq(cnt);
        for (int i = 0; i < cnt; i++) begin
            p = (fixed_p < 0) ? 7'($urandom) : 7'(fixed_p);
            h = rand_hold ? ($urandom_range(0, 2) == 0) : 1'b0;
            do_term(i, p, $urandom_range(1, 4), prev_hold, h);
            prev_hold = h;
        end
        finish_seq(cnt);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Go = 1'b1;
        Count = 4'd5;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (MulSt !== 1'b0 || SumValid !== 1'b0 || Ovf !== 1'b0 || Sum !== 9'h000 || TermIdx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got st=%b v=%b o=%b s=%h t=%0d want 0 0 0 000 0",
                     MulSt, SumValid, Ovf, Sum, TermIdx);
        end
        Rst = 1'b0;
        Go = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if (MulSt !== 1'b0 || SumValid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got st=%b v=%b want 0 0", MulSt, SumValid);
        end
    endtask

    task automatic test_single();
        run_seq(1, 'h20, 0);
        n_tests++;
        if (Sum !== 9'h020 || Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single got sum=%h ovf=%b want 020 0", Sum, Ovf);
        end
    endtask

    task automatic test_zero_count();
        start_seq(0);
        n_tests++;
        if (SumValid !== 1'b1 || Sum !== 9'h000 || MulSt !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count got v=%b sum=%h st=%b want 1 000 0", SumValid, Sum, MulSt);
        end
        finish_seq(0);
    endtask

    task automatic test_three();
        run_seq(3, 'h30, 0);
        n_tests++;
        if (Sum !== 9'h090 || Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL three got sum=%h ovf=%b want 090 0", Sum, Ovf);
        end
    endtask

    task automatic test_saturate();
        run_seq(6, 'h30, 0);
        n_tests++;
        if (Sum !== 9'h0FF || Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got sum=%h ovf=%b want 0ff 1", Sum, Ovf);
        end
        run_seq(5, 'h40, 0);
        n_tests++;
        if (Sum !== 9'h100 || Ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg got sum=%h ovf=%b want 100 1", Sum, Ovf);
        end
    endtask

    task automatic test_held_done();
        start_seq(3);
        do_term(0, 7'h11, 2, 0, 1);
        do_term(1, 7'h05, 1, 1, 1);
        do_term(2, 7'h7F, 3, 1, 0);
        finish_seq(3);
        n_tests++;
        if (Sum !== 9'h015) begin
            n_fail++;
            $display("FAIL held_sum got %h want 015", Sum);
        end
    endtask

    task automatic test_abort();
        bit ok;
        start_seq(3);
        do_term(0, 7'h08, 2, 0, 0);
        do_term(1, 7'h08, 2, 0, 0);
        wait_mulst(ok);
        @(negedge CLK);
        Rst = 1'b1;
        @(negedge CLK);
        Rst = 1'b0;
        mulst_base = mulst_total;
        n_tests++;
        if (MulSt !== 1'b0 || SumValid !== 1'b0 || Ovf !== 1'b0 || Sum !== 9'h000 || TermIdx !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_reset got st=%b v=%b o=%b s=%h t=%0d want 0 0 0 000 0",
                     MulSt, SumValid, Ovf, Sum, TermIdx);
        end
        repeat (2) @(negedge CLK);
        Product = 7'h3F;
        MulDone = 1'b1;
        repeat (2) @(negedge CLK);
        MulDone = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (Sum !== 9'h000 || SumValid !== 1'b0 || (mulst_total - mulst_base) != 0) begin
            n_fail++;
            $display("FAIL abort_ignore got sum=%h v=%b pulses=%0d want 000 0 0",
                     Sum, SumValid, mulst_total - mulst_base);
        end
        run_seq(1, 'h10, 0);
        n_tests++;
        if (Sum !== 9'h010) begin
            n_fail++;
            $display("FAIL abort_resume got %h want 010", Sum);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            run_seq($urandom_range(1, 15), -1, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_three();
        test_saturate();
        test_held_done();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
